// File: rtl/cia_addsub_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cia_addsub_seq_if
//  Description : Request/response bundle for the sequential carry-increment
//                adder/subtractor. The request side carries operands and the
//                add/subtract select. The response side carries the result,
//                carry-out and signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cia_addsub_seq_if #(
    parameter int WIDTH = 32
) ();

    // request channel
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;

    // response channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    // operand source / result consumer side
    modport master (
        output in_valid,
        output op,
        output in1,
        output in2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  cout,
        input  ovf
    );

    // arithmetic block side
    modport slave (
        input  in_valid,
        input  op,
        input  in1,
        input  in2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output cout,
        output ovf
    );

endinterface : cia_addsub_seq_if
`default_nettype wire

// File: rtl/cia_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cia_addsub_seq
//  Description : Sequential WIDTH-bit adder/subtractor. A request latches the
//                operands (B inverted for subtract, carry-in = op) and the
//                block then resolves one SLICE-bit slice per clock, rippling
//                the slice carry forward. The result, final carry and signed
//                overflow are offered on a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module cia_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    cia_addsub_seq_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               c_q,      c_d;
    logic [KW-1:0]      k_q,      k_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // per-slice views of the operands and the result with slice k replaced
    logic [SLICE-1:0]   w_a_sl [0:NSLICE-1];
    logic [SLICE-1:0]   w_b_sl [0:NSLICE-1];
    logic [WIDTH-1:0]   w_res_upd;
    logic [SLICE-1:0]   w_a_cur;
    logic [SLICE-1:0]   w_b_cur;
    logic [SLICE:0]     w_sum;

    // slice extraction and in-place write-back of the current slice sum
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign w_a_sl[gi] = a_q[gi*SLICE +: SLICE];
        assign w_b_sl[gi] = b_q[gi*SLICE +: SLICE];
        assign w_res_upd[gi*SLICE +: SLICE] =
            (k_q == KW'(gi)) ? w_sum[SLICE-1:0] : result_q[gi*SLICE +: SLICE];
    end

    assign w_a_cur = w_a_sl[k_q];
    assign w_b_cur = w_b_sl[k_q];

    // SLICE+1-bit slice add: the top bit is the carry into the next slice
    assign w_sum = {1'b0, w_a_cur} + {1'b0, w_b_cur} + {{SLICE{1'b0}}, c_q};

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    // next-state and datapath update; registers hold unless a state acts
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        k_d      = k_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // subtract is A + ~B + 1: the +1 rides in as the carry
                    a_d      = bus.in1;
                    b_d      = bus.op ? ~bus.in2 : bus.in2;
                    c_d      = bus.op;
                    k_d      = '0;
                    result_d = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                result_d = w_res_upd;
                c_d      = w_sum[SLICE];
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.cout      = c_q;
    // overflow uses the latched B, so for subtract it sees the inverted operand
    assign bus.ovf       = (a_q[MSB] == b_q[MSB]) && (result_q[MSB] != a_q[MSB]);

endmodule : cia_addsub_seq
`default_nettype wire

// File: tb/tb_cia_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cia_addsub_seq
//  Description : Directed self-checking bench for cia_addsub_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cia_addsub_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cia_addsub_seq_if #(.WIDTH(32)) bus ();

    cia_addsub_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one full transaction: wait ready, issue, measure latency, check response,
    // optionally hold off the consumer and inject ignored requests
    task automatic run_op(input string name, input logic op_v,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic eo,
                          input int hold, input bit junk);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, ".req_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op_v;
        bus.in1      = a;
        bus.in2      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({name, ".busy"}, 32'(bus.in_ready), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.op       = ~bus.op;
                bus.in1      = $urandom;
                bus.in2      = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check({name, ".latency"}, 32'(n), 32'd4);
        check({name, ".result"}, bus.result, er);
        check({name, ".cout"}, 32'(bus.cout), 32'(ec));
        check({name, ".ovf"}, 32'(bus.ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            if (junk) bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({name, ".hold_result"}, bus.result, er);
            check({name, ".hold_cout"}, 32'(bus.cout), 32'(ec));
            check({name, ".hold_ovf"}, 32'(bus.ovf), 32'(eo));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({name, ".ready_rise"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check({name, ".stay_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;

        // reset state
        #7;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.cout", 32'(bus.cout), 32'd0);
        check("rst.ovf", 32'(bus.ovf), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // arithmetic vectors
        run_op("pos_ovf",  1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 0, 1'b0);
        run_op("neg_ovf",  1'b0, 32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b1, 0, 1'b0);
        run_op("mixed",    1'b0, 32'h70FF_9FFC, 32'hF2FD_9FFC, 32'h63FD_3FF8, 1'b1, 1'b0, 0, 1'b0);
        run_op("sub_borr", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("chain",    1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("zero",     1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);

        // backpressure with ignored requests during CALC and DONE
        run_op("bp_add",   1'b0, 32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0, 1'b0, 5, 1'b1);
        run_op("bp_sub",   1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 5, 1'b1);

        // reset in the middle of CALC, with two slices already written
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.in1      = 32'h1234_5678;
        bus.in2      = 32'h1111_1111;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid.partial", bus.result, 32'h0000_6789);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", 32'(bus.out_valid), 32'd0);
        check("mid.in_ready", 32'(bus.in_ready), 32'd1);
        check("mid.result", bus.result, 32'd0);
        check("mid.cout", 32'(bus.cout), 32'd0);
        check("mid.ovf", 32'(bus.ovf), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst.no_resp", 32'(bus.out_valid), 32'd0);
        run_op("post_rst", 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cia_addsub_seq
`default_nettype wire
